sid_audio_tx: RTL and testbench

Audio output transmitter for the SID block: paces the filter by issuing one sample request per audio frame, captures the filter's 18-bit `sound` result and serializes it as a stereo I2S stream (the same mono sample in both slots). It sits between the SID filter output and the board DAC. It is the sink end of the filter's `input_valid`/`sound` interface and owns the system sample rate.

---
 rtl/sid_audio_pkg.sv | 10 +
 rtl/sid_sdm.sv | 33 +++
 rtl/sid_audio_tx.sv | 112 +++++++++++
 tb/tb_sid_audio_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_audio_pkg.sv
// Shared widths, I2S slot layout and sample type for the SID audio output path.
package sid_audio_pkg;

    localparam int unsigned SID_SAMPLE_W       = 18;
    localparam int unsigned I2S_DATA_POS_FIRST = 1;
    localparam int unsigned I2S_DATA_POS_LAST  = 18;

    typedef logic signed [SID_SAMPLE_W-1:0] sid_sample_t;

endpackage : sid_audio_pkg

// File: rtl/sid_sdm.sv
// First-order sigma-delta modulator: offset-binary sample in, 1-bit density out.
module sid_sdm
    import sid_audio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  sid_sample_t sample,
    output logic        pdm_out
);

    // Flipping the sign bit maps two's complement onto offset binary.
    localparam logic [SID_SAMPLE_W-1:0] OFFSET = {1'b1, {(SID_SAMPLE_W-1){1'b0}}};

    logic [SID_SAMPLE_W:0] acc_q;
    logic [SID_SAMPLE_W:0] acc_d;

    // Accumulate the low bits plus the offset sample; the carry is the output bit.
    always_comb begin
        acc_d = {1'b0, acc_q[SID_SAMPLE_W-1:0]} + {1'b0, sample ^ OFFSET};
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign pdm_out = acc_q[SID_SAMPLE_W];

endmodule : sid_sdm

// File: rtl/sid_audio_tx.sv
// SID audio transmitter: paces the filter with one sample request per frame,
// captures the result and sends it as stereo I2S (same sample in both slots).
// Optional feature macro: SID_AUDIO_TX_PDM_EN adds the pdm_out sigma-delta output.
module sid_audio_tx
    import sid_audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned SLOT_W  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  sid_sample_t sound,
    input  logic        mute,
    output logic        sample_req,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
`ifdef SID_AUDIO_TX_PDM_EN
    ,
    output logic        pdm_out
`endif
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = $clog2(2 * SLOT_W);
    localparam int unsigned IDX_W = $clog2(SID_SAMPLE_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             req_q, req_d;
    sid_sample_t      hold_q, hold_d;

    logic             tick;
    logic             fall;
    logic [BIT_W-1:0] bit_nxt;
    logic [BIT_W-1:0] slot_pos;
    logic [IDX_W-1:0] data_idx;

    // Divider, bit counter, frame-start capture and serial data selection.
    always_comb begin
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        req_d     = 1'b0;
        hold_d    = hold_q;

        tick     = (div_cnt_q == DIV_W'(CLK_DIV - 1));
        fall     = tick & bclk_q;
        bit_nxt  = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        slot_pos = (bit_nxt >= BIT_W'(SLOT_W)) ? bit_nxt - BIT_W'(SLOT_W) : bit_nxt;
        data_idx = IDX_W'(BIT_W'(I2S_DATA_POS_LAST) - slot_pos);

        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
            bclk_d = ~bclk_q;
        end

        if (fall) begin
            bit_cnt_d = bit_nxt;
            lrclk_d   = (bit_nxt >= BIT_W'(SLOT_W));
            // Position 0 is the I2S one-bit delay; the MSB follows one bclk later.
            sdata_d   = (slot_pos >= BIT_W'(I2S_DATA_POS_FIRST)) &&
                        (slot_pos <= BIT_W'(I2S_DATA_POS_LAST)) ? hold_q[data_idx] : 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
                req_d  = 1'b1;
                hold_d = mute ? '0 : sound;
            end
        end
    end

    // State registers; bit_cnt starts at its last value so the first fall opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= BIT_LAST;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            req_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            req_q     <= req_d;
            hold_q    <= hold_d;
        end
    end

    assign sample_req = req_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;

`ifdef SID_AUDIO_TX_PDM_EN
    sid_sdm u_sdm (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (hold_q),
        .pdm_out (pdm_out)
    );
`endif

endmodule : sid_audio_tx

// File: tb/tb_sid_audio_tx.sv
// Directed self-checking bench for sid_audio_tx with CLK_DIV=2, SLOT_W=32.
module tb_sid_audio_tx;

    logic        clk;
    logic        rst_n;
    logic [17:0] sound;
    logic        mute;
    logic        sample_req;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
`ifdef SID_AUDIO_TX_PDM_EN
    logic        pdm_out;
`endif

    int n_cmp;
    int n_fail;

    sid_audio_tx #(
        .CLK_DIV (2),
        .SLOT_W  (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sound      (sound),
        .mute       (mute),
        .sample_req (sample_req),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdata  (i2s_sdata)
`ifdef SID_AUDIO_TX_PDM_EN
        ,
        .pdm_out    (pdm_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) for a sample_req pulse, sampled on the falling clk edge.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sample_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Record one frame MSB-first: bit 63 is left slot position 0.
    task automatic capture_frame(input int chg_at, input logic [17:0] chg_sound,
                                 input logic chg_mute, output logic [63:0] sd,
                                 output logic [63:0] lr, output bit ok);
        sd = '0;
        lr = '0;
        wait_req(ok);
        if (ok) begin
            for (int b = 0; b < 64; b++) begin
                sd[63-b] = i2s_sdata;
                lr[63-b] = i2s_lrclk;
                if (b == chg_at) begin
                    sound = chg_sound;
                    mute  = chg_mute;
                end
                if (b != 63) repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no sample_req within bound", name);
    endtask

    // Check both slots of a captured frame against an expected 18-bit sample.
    task automatic test_frame(input string name, input int chg_at,
                              input logic [17:0] chg_sound, input logic chg_mute,
                              input logic [17:0] exp_h);
        logic [63:0] sd, lr;
        logic [31:0] exp_slot;
        bit ok;
        exp_slot = {1'b0, exp_h, 13'b0};
        capture_frame(chg_at, chg_sound, chg_mute, sd, lr, ok);
        if (!ok) begin
            timeout_fail(name);
        end else begin
            n_cmp++;
            if (sd[63:32] !== exp_slot) begin
                n_fail++;
                $display("FAIL %s left: got %h expected %h", name, sd[63:32], exp_slot);
            end
            n_cmp++;
            if (sd[31:0] !== exp_slot) begin
                n_fail++;
                $display("FAIL %s right: got %h expected %h", name, sd[31:0], exp_slot);
            end
            n_cmp++;
            if (lr !== {32'h0, 32'hFFFF_FFFF}) begin
                n_fail++;
                $display("FAIL %s lrclk: got %h expected %h", name, lr, {32'h0, 32'hFFFF_FFFF});
            end
        end
    endtask

    task automatic test_reset;
        logic e;
        int   period;
        rst_n = 1'b0;
        sound = 18'h2A5C3;
        mute  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({sample_req, i2s_bclk, i2s_lrclk, i2s_sdata} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {sample_req, i2s_bclk, i2s_lrclk, i2s_sdata});
        end
`ifdef SID_AUDIO_TX_PDM_EN
        n_cmp++;
        if (pdm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pdm: got %b expected 0", pdm_out);
        end
`endif
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            e = (k == 4);
            n_cmp++;
            if (sample_req !== e) begin
                n_fail++;
                $display("FAIL first_req clk%0d: got %b expected %b", k, sample_req, e);
            end
            e = (((k / 2) % 2) == 1);
            n_cmp++;
            if (i2s_bclk !== e) begin
                n_fail++;
                $display("FAIL first_bclk clk%0d: got %b expected %b", k, i2s_bclk, e);
            end
        end
        period = -1;
        for (int i = 9; i < 400; i++) begin
            @(negedge clk);
            if (sample_req === 1'b1) begin
                period = i - 4;
                break;
            end
        end
        n_cmp++;
        if (period != 256) begin
            n_fail++;
            $display("FAIL req_period: got %0d expected 256", period);
        end
        @(negedge clk);
        n_cmp++;
        if (sample_req !== 1'b0) begin
            n_fail++;
            $display("FAIL req_width: got %b expected 0", sample_req);
        end
    endtask

    task automatic test_serialization;
        test_frame("serial_2A5C3", -1, 18'h0, 1'b0, 18'h2A5C3);
    endtask

    task automatic test_bclk_lrclk;
        bit ok;
        int bad_bclk, bad_lr;
        bad_bclk = 0;
        bad_lr   = 0;
        wait_req(ok);
        if (!ok) begin
            timeout_fail("bclk_lrclk");
        end else begin
            for (int i = 0; i < 256; i++) begin
                if (i != 0) @(negedge clk);
                if (i2s_bclk !== ((i % 4) >= 2)) bad_bclk++;
                if (i2s_lrclk !== (i >= 128)) bad_lr++;
            end
            n_cmp++;
            if (bad_bclk != 0) begin
                n_fail++;
                $display("FAIL bclk_shape: got %0d bad cycles expected 0", bad_bclk);
            end
            n_cmp++;
            if (bad_lr != 0) begin
                n_fail++;
                $display("FAIL lrclk_shape: got %0d bad cycles expected 0", bad_lr);
            end
        end
    endtask

    task automatic test_mid_frame_change;
        sound = 18'h00001;
        test_frame("midframe_cur", 10, 18'h3FFFF, 1'b0, 18'h00001);
        test_frame("midframe_next", -1, 18'h0, 1'b0, 18'h3FFFF);
    endtask

    task automatic test_mute;
        mute = 1'b1;
        test_frame("mute_frame", 10, 18'h3FFFF, 1'b0, 18'h00000);
        test_frame("unmute_next", -1, 18'h0, 1'b0, 18'h3FFFF);
    endtask

`ifdef SID_AUDIO_TX_PDM_EN
    task automatic test_pdm;
        bit ok;
        int ones;
        sound = 18'h00000;
        wait_req(ok);
        if (!ok) timeout_fail("pdm_half");
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (pdm_out === 1'b1) ones++;
        end
        n_cmp++;
        if (ones < 511 || ones > 513) begin
            n_fail++;
            $display("FAIL pdm_half: got %0d ones expected 511..513", ones);
        end
        sound = 18'h1FFFF;
        wait_req(ok);
        if (!ok) timeout_fail("pdm_full");
        ones = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (pdm_out === 1'b1) ones++;
        end
        n_cmp++;
        if (ones < 1020) begin
            n_fail++;
            $display("FAIL pdm_full: got %0d ones expected >=1020", ones);
        end
    endtask
`endif

    task automatic test_reset_mid_frame;
        bit ok;
        logic e;
        sound = 18'h3FFFF;
        wait_req(ok);
        if (!ok) timeout_fail("reset_mid");
        repeat (70) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sample_req, i2s_bclk, i2s_lrclk, i2s_sdata} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 0000",
                     {sample_req, i2s_bclk, i2s_lrclk, i2s_sdata});
        end
`ifdef SID_AUDIO_TX_PDM_EN
        n_cmp++;
        if (pdm_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pdm: got %b expected 0", pdm_out);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = (k == 4);
            n_cmp++;
            if (sample_req !== e) begin
                n_fail++;
                $display("FAIL rerelease_req clk%0d: got %b expected %b", k, sample_req, e);
            end
        end
        // The frame after re-release carries the sample captured at its start.
        test_frame("after_reset", -1, 18'h0, 1'b0, 18'h3FFFF);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset;
        test_serialization;
        test_bclk_lrclk;
        test_mid_frame_change;
        test_mute;
`ifdef SID_AUDIO_TX_PDM_EN
        test_pdm;
`endif
        test_reset_mid_frame;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_sid_audio_tx
